// File: rtl/ramio_pkg.sv
// Shared encodings for the ramio cache front end: access sizes, burst
// command codes, miss-service FSM states and the load extension helper.
package ramio_pkg;

    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_BYTE = 2'b01,
        WE_HALF = 2'b10,
        WE_WORD = 2'b11
    } we_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } re_size_e;

    localparam int unsigned RE_SIGN_BIT = 2;

    typedef enum logic {
        BR_READ  = 1'b0,
        BR_WRITE = 1'b1
    } br_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_WB_BEATS,
        ST_RD,
        ST_FILL
    } state_e;

    // Selects the byte/half/word of an aligned 32-bit word and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  re);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sgn;
        b   = word[{off, 3'b000} +: 8];
        h   = off[1] ? word[31:16] : word[15:0];
        sgn = re[RE_SIGN_BIT];
        case (re_size_e'(re[1:0]))
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            SZ_WORD: return word;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ramio_burst_ctrl.sv
// Miss-service FSM: optional victim write-back burst, then a line fill,
// driving the registered br_ command/data signals.
module ramio_burst_ctrl
    import ramio_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    localparam int BEAT_W = $clog2(RAM_BURST_DATA_COUNT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               victim_dirty,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]      victim_addr,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]      fill_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] wb_data,
    input  logic                               br_busy,
    input  logic                               br_rd_data_valid,
    output logic                               idle,
    output logic [BEAT_W-1:0]                  beat_ix,
    output logic                               fill_we,
    output logic                               fill_last,
    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0] br_wr_data
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);

    state_e                          state;
    br_cmd_e                         cmd;
    logic [BEAT_W-1:0]               cnt;
    logic [RAM_DEPTH_BITWIDTH-1:0]   vic_q;
    logic [RAM_DEPTH_BITWIDTH-1:0]   new_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cmd        <= BR_READ;
            cnt        <= '0;
            vic_q      <= '0;
            new_q      <= '0;
            br_cmd_en  <= 1'b0;
            br_addr    <= '0;
            br_wr_data <= '0;
        end else begin
            br_cmd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vic_q <= victim_addr;
                        new_q <= fill_addr;
                        cnt   <= '0;
                        state <= victim_dirty ? ST_WB : ST_RD;
                    end
                end
                ST_WB: begin
                    // beat 0 travels with the command strobe
                    if (!br_busy) begin
                        br_cmd_en  <= 1'b1;
                        cmd        <= BR_WRITE;
                        br_addr    <= vic_q;
                        br_wr_data <= wb_data;
                        cnt        <= BEAT_W'(1);
                        state      <= ST_WB_BEATS;
                    end
                end
                ST_WB_BEATS: begin
                    br_wr_data <= wb_data;
                    if (cnt == LAST_BEAT) begin
                        cnt   <= '0;
                        state <= ST_RD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RD: begin
                    if (!br_busy) begin
                        br_cmd_en <= 1'b1;
                        cmd       <= BR_READ;
                        br_addr   <= new_q;
                        cnt       <= '0;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (br_rd_data_valid) begin
                        if (cnt == LAST_BEAT) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign br_cmd    = cmd;
    assign idle      = (state == ST_IDLE);
    assign beat_ix   = cnt;
    assign fill_we   = (state == ST_FILL) && br_rd_data_valid;
    assign fill_last = fill_we && (cnt == LAST_BEAT);

endmodule

// File: rtl/ramio.sv
// Direct-mapped write-back cache shared by a data port (A) and an
// instruction port (B), refilled by whole-line bursts from BurstRAM.
module ramio
    import ramio_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int CACHE_LINE_IX_BITWIDTH  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enA,
    input  logic [1:0]                           weA,
    input  logic [2:0]                           reA,
    input  logic [31:0]                          addrA,
    input  logic [31:0]                          dinA,
    output logic [31:0]                          doutA,
    output logic                                 validA,
    output logic                                 bsyA,
    input  logic                                 enB,
    input  logic [31:0]                          addrB,
    output logic [31:0]                          doutB,
    output logic                                 validB,
    output logic                                 bsyB,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int BEAT_W = $clog2(RAM_BURST_DATA_COUNT);
    localparam int OFF_W  = BEAT_W + 3;
    localparam int IX_W   = CACHE_LINE_IX_BITWIDTH;
    localparam int LINES  = 2 ** IX_W;
    localparam int AB     = RAM_DEPTH_BITWIDTH + 3;
    localparam int TAG_W  = AB - OFF_W - IX_W;

    logic [RAM_BURST_DATA_BITWIDTH-1:0] line_data [LINES][RAM_BURST_DATA_COUNT];
    logic [TAG_W-1:0]                   tag_q [LINES];
    logic [LINES-1:0]                   valid_q;
    logic [LINES-1:0]                   dirty_q;
    logic [IX_W-1:0]                    fill_ix_q;
    logic [TAG_W-1:0]                   fill_tag_q;

    logic [IX_W-1:0]   ix_a, ix_b, svc_ix;
    logic [TAG_W-1:0]  tag_a, tag_b, svc_tag;
    logic [BEAT_W-1:0] beat_a, beat_b, beat_ix;
    logic              hit_a, hit_b, need_a, need_b, start, store_a;
    logic              idle, fill_we, fill_last, victim_dirty;
    logic [31:0]       word_a, word_b;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] beat_data_a, beat_data_b;
    logic              unused_addr_bits;

    assign ix_a   = addrA[OFF_W +: IX_W];
    assign tag_a  = addrA[OFF_W + IX_W +: TAG_W];
    assign beat_a = addrA[3 +: BEAT_W];
    assign ix_b   = addrB[OFF_W +: IX_W];
    assign tag_b  = addrB[OFF_W + IX_W +: TAG_W];
    assign beat_b = addrB[3 +: BEAT_W];

    assign hit_a = valid_q[ix_a] && (tag_q[ix_a] == tag_a);
    assign hit_b = valid_q[ix_b] && (tag_q[ix_b] == tag_b);

    assign beat_data_a = line_data[ix_a][beat_a];
    assign beat_data_b = line_data[ix_b][beat_b];
    assign word_a = addrA[2] ? beat_data_a[63:32] : beat_data_a[31:0];
    assign word_b = addrB[2] ? beat_data_b[63:32] : beat_data_b[31:0];

    assign validA = enA && (reA != 3'b000) && hit_a;
    assign doutA  = validA ? load_extend(word_a, addrA[1:0], reA) : '0;
    assign validB = enB && hit_b;
    assign doutB  = validB ? word_b : '0;

    assign bsyA = !rst || (enA && (!hit_a || !idle));
    assign bsyB = !rst || (enB && (!hit_b || !idle));

    assign need_a  = enA && !hit_a;
    assign need_b  = enB && !hit_b;
    assign start   = idle && (need_a || need_b);
    assign svc_ix  = need_a ? ix_a : ix_b;
    assign svc_tag = need_a ? tag_a : tag_b;
    assign store_a = enA && (weA != 2'b00) && hit_a && idle;

    // A store landing on the victim in the same cycle a B miss starts
    // must still force the write-back.
    assign victim_dirty = valid_q[svc_ix] &&
                          (dirty_q[svc_ix] || (store_a && (ix_a == svc_ix)));

    assign br_data_mask     = '0;
    assign unused_addr_bits = ^{addrA[31:AB], addrB[31:AB], addrB[1:0]};

    ramio_burst_ctrl #(
        .RAM_DEPTH_BITWIDTH      (RAM_DEPTH_BITWIDTH),
        .RAM_BURST_DATA_COUNT    (RAM_BURST_DATA_COUNT),
        .RAM_BURST_DATA_BITWIDTH (RAM_BURST_DATA_BITWIDTH)
    ) u_ctrl (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .victim_dirty     (victim_dirty),
        .victim_addr      ({tag_q[svc_ix], svc_ix, {BEAT_W{1'b0}}}),
        .fill_addr        ({svc_tag, svc_ix, {BEAT_W{1'b0}}}),
        .wb_data          (line_data[fill_ix_q][beat_ix]),
        .br_busy          (br_busy),
        .br_rd_data_valid (br_rd_data_valid),
        .idle             (idle),
        .beat_ix          (beat_ix),
        .fill_we          (fill_we),
        .fill_last        (fill_last),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data)
    );

    // The line being replaced is invalidated at miss start so partially
    // filled data can never produce a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            fill_ix_q  <= '0;
            fill_tag_q <= '0;
        end else begin
            if (start) begin
                fill_ix_q       <= svc_ix;
                fill_tag_q      <= svc_tag;
                valid_q[svc_ix] <= 1'b0;
            end
            if (store_a) begin
                dirty_q[ix_a] <= 1'b1;
            end
            if (fill_last) begin
                valid_q[fill_ix_q] <= 1'b1;
                dirty_q[fill_ix_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_a) begin
            case (we_e'(weA))
                WE_BYTE: line_data[ix_a][beat_a][{addrA[2:0], 3'b000} +: 8]  <= dinA[7:0];
                WE_HALF: line_data[ix_a][beat_a][{addrA[2:1], 4'b0000} +: 16] <= dinA[15:0];
                WE_WORD: line_data[ix_a][beat_a][{addrA[2], 5'b00000} +: 32] <= dinA;
                default: ;
            endcase
        end
        if (fill_we) begin
            line_data[fill_ix_q][beat_ix] <= br_rd_data;
        end
        if (fill_last) begin
            tag_q[fill_ix_q] <= fill_tag_q;
        end
    end

endmodule

// File: tb/tb_ramio.sv
// Scoreboard bench for ramio: byte-array reference memory, a BurstRAM
// model, and monitors that pop expected load results as ports complete.
module tb_ramio;

    localparam int DEPTH = 8;
    localparam int NB    = 4;
    localparam int LAT   = 3;
    localparam int WORDS = 2 ** DEPTH;
    localparam int BYTES = WORDS * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enA, enB;
    logic [1:0]  weA;
    logic [2:0]  reA;
    logic [31:0] addrA, dinA, doutA, addrB, doutB;
    logic        validA, bsyA, validB, bsyB;
    logic        br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [DEPTH-1:0] br_addr;
    logic [63:0] br_wr_data, br_rd_data;
    logic [7:0]  br_data_mask;
    logic        ram_busy, force_busy;

    logic [63:0] ram  [WORDS];
    logic [7:0]  refm [BYTES];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    int unsigned wb_count = 0, rd_count = 0, cyc = 0;
    logic [1:0]  last_cmds = 2'b00;
    int unsigned n_checks = 0, n_pass = 0;

    assign br_busy = ram_busy | force_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ramio #(
        .RAM_DEPTH_BITWIDTH      (DEPTH),
        .RAM_BURST_DATA_COUNT    (NB),
        .RAM_BURST_DATA_BITWIDTH (64),
        .CACHE_LINE_IX_BITWIDTH  (1)
    ) dut (
        .clk(clk), .rst(rst),
        .enA(enA), .weA(weA), .reA(reA), .addrA(addrA), .dinA(dinA),
        .doutA(doutA), .validA(validA), .bsyA(bsyA),
        .enB(enB), .addrB(addrB), .doutB(doutB), .validB(validB), .bsyB(bsyB),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] re);
        int unsigned a;
        logic [7:0]  b;
        logic [15:0] h;
        a = addr & 32'h7FF;
        case (re[1:0])
            2'b01: begin b = refm[a]; return re[2] ? {{24{b[7]}}, b} : {24'h0, b}; end
            2'b10: begin a = a & ~32'd1; h = {refm[a+1], refm[a]};
                         return re[2] ? {{16{h[15]}}, h} : {16'h0, h}; end
            2'b11: begin a = a & ~32'd3; return {refm[a+3], refm[a+2], refm[a+1], refm[a]}; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] we, input logic [31:0] d);
        int unsigned a;
        a = addr & 32'h7FF;
        case (we)
            2'b01: refm[a] = d[7:0];
            2'b10: begin a = a & ~32'd1; refm[a] = d[7:0]; refm[a+1] = d[15:8]; end
            2'b11: begin a = a & ~32'd3;
                         for (int k = 0; k < 4; k++) refm[a+k] = d[8*k +: 8]; end
            default: ;
        endcase
    endtask

    task automatic rebuild_ref();
        for (int w = 0; w < WORDS; w++)
            for (int k = 0; k < 8; k++) refm[w*8+k] = ram[w][8*k +: 8];
    endtask

    task automatic opA(input logic [31:0] addr, input logic [1:0] we, input logic [2:0] re,
                       input logic [31:0] d, output int unsigned done_cyc);
        bit got = 0;
        @(posedge clk); #1;
        if (re != 3'b000) qa.push_back(ref_load(addr, re));
        ref_store(addr, we, d);
        enA = 1'b1; weA = we; reA = re; addrA = addr; dinA = d;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!bsyA) begin got = 1; break; end
        end
        check("A_served", 64'(got), 64'd1);
        done_cyc = cyc;
        @(posedge clk); #1;
        enA = 1'b0; weA = 2'b00; reA = 3'b000;
    endtask

    task automatic opB(input logic [31:0] addr, output int unsigned done_cyc);
        bit got = 0;
        @(posedge clk); #1;
        qb.push_back(ref_load(addr, 3'b011));
        enB = 1'b1; addrB = addr;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!bsyB) begin got = 1; break; end
        end
        check("B_served", 64'(got), 64'd1);
        done_cyc = cyc;
        @(posedge clk); #1;
        enB = 1'b0;
    endtask

    // BurstRAM model: write beats follow the strobe, reads answer after LAT cycles.
    initial begin
        logic [DEPTH-1:0] ra;
        ram_busy = 1'b0; br_rd_data_valid = 1'b0; br_rd_data = '0;
        forever begin
            @(negedge clk);
            if (rst && br_cmd_en) begin
                ra = br_addr;
                last_cmds = {last_cmds[0], br_cmd};
                if (br_cmd) begin
                    wb_count++;
                    ram[ra] = br_wr_data;
                    for (int i = 1; i < NB; i++) begin
                        @(negedge clk);
                        if (i == 1) ram_busy = 1'b1;
                        ram[ra + DEPTH'(i)] = br_wr_data;
                    end
                    repeat (2) @(negedge clk);
                    ram_busy = 1'b0;
                end else begin
                    rd_count++;
                    @(negedge clk);
                    ram_busy = 1'b1;
                    repeat (LAT) @(negedge clk);
                    for (int i = 0; i < NB; i++) begin
                        br_rd_data = ram[ra + DEPTH'(i)];
                        br_rd_data_valid = 1'b1;
                        @(negedge clk);
                    end
                    br_rd_data_valid = 1'b0;
                    ram_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (validA && !bsyA) begin
            if (qa.size() == 0) check("A_unexpected", 64'(doutA), 64'hX);
            else check("loadA", 64'(doutA), 64'(qa.pop_front()));
        end
        if (validB && !bsyB) begin
            if (qb.size() == 0) check("B_unexpected", 64'(doutB), 64'hX);
            else check("loadB", 64'(doutB), 64'(qb.pop_front()));
        end
        if (br_cmd_en) check("cmd_en_while_busy", 64'(br_busy), 64'd0);
    end

    initial begin
        int unsigned da, db, w0, r0, c0;
        bit saw;
        logic [31:0] ad;
        logic [1:0]  we;
        logic [2:0]  re;
        enA = 0; weA = 0; reA = 0; addrA = 0; dinA = 0; enB = 0; addrB = 0;
        force_busy = 1'b0;
        for (int w = 0; w < WORDS; w++) ram[w] = {$urandom, $urandom};
        rebuild_ref();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bsyA", 64'(bsyA), 64'd1);
        check("rst_bsyB", 64'(bsyB), 64'd1);
        check("rst_cmd_en", 64'(br_cmd_en), 64'd0);
        check("rst_cmd", 64'(br_cmd), 64'd0);
        check("rst_addr", 64'(br_addr), 64'd0);
        check("rst_wr_data", br_wr_data, 64'd0);
        check("rst_mask", 64'(br_data_mask), 64'd0);
        check("rst_validA", 64'(validA), 64'd0);
        check("rst_validB", 64'(validB), 64'd0);
        check("rst_doutA", 64'(doutA), 64'd0);
        check("rst_doutB", 64'(doutB), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("idle_bsyA", 64'(bsyA), 64'd0);

        opA(0, 2'b01, 3'b000, 32'h12, da);
        opA(1, 2'b01, 3'b000, 32'h34, da);
        opA(2, 2'b01, 3'b000, 32'h56, da);
        opA(3, 2'b01, 3'b000, 32'h78, da);
        opA(0, 2'b00, 3'b111, 0, da);
        opA(4, 2'b10, 3'b000, 32'h1234, da);
        opA(6, 2'b10, 3'b000, 32'h5678, da);
        opA(4, 2'b00, 3'b011, 0, da);
        opA(6, 2'b00, 3'b010, 0, da);
        opA(1, 2'b00, 3'b001, 0, da);
        opA(8, 2'b11, 3'b000, 32'hFFFEFDFC, da);
        for (int k = 8; k < 12; k++) opA(k, 2'b00, 3'b101, 0, da);
        opA(8, 2'b00, 3'b110, 0, da);
        opA(10, 2'b00, 3'b110, 0, da);
        opA(12, 2'b11, 3'b011, 32'hA5A5A5A5, da);

        opA(0, 2'b11, 3'b000, 32'hDEADBEEF, da);
        w0 = wb_count;
        opB(64, db);
        check("wb_before_fill_count", 64'(wb_count - w0), 64'd1);
        check("wb_then_rd_order", 64'(last_cmds), 64'b10);
        check("wb_ram_word0", 64'(ram[0][31:0]), 64'hDEADBEEF);
        opA(0, 2'b00, 3'b011, 0, da);

        r0 = rd_count;
        fork
            opA(32'h100, 2'b00, 3'b011, 0, da);
            opB(32'h1A0, db);
        join
        check("prio_A_first", 64'(da < db), 64'd1);
        check("prio_two_fills", 64'(rd_count - r0), 64'd2);

        @(negedge clk); force_busy = 1'b1;
        c0 = wb_count + rd_count;
        fork
            opA(32'h300, 2'b00, 3'b011, 0, da);
            begin
                repeat (20) @(negedge clk);
                check("busy_hold_no_cmd", 64'(wb_count + rd_count - c0), 64'd0);
                check("busy_hold_bsyA", 64'(bsyA), 64'd1);
                force_busy = 1'b0;
            end
        join

        @(posedge clk); #1 enB = 1'b1; addrB = 32'h5A0;
        saw = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (br_rd_data_valid) begin saw = 1; break; end
        end
        check("midburst_fill_seen", 64'(saw), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_bsyB", 64'(bsyB), 64'd1);
        check("midrst_validB", 64'(validB), 64'd0);
        check("midrst_cmd_en", 64'(br_cmd_en), 64'd0);
        enB = 1'b0;
        for (int c = 0; c < 100 && ram_busy; c++) @(negedge clk);
        check("ram_idle", 64'(ram_busy), 64'd0);
        rst = 1'b1;
        rebuild_ref();
        r0 = rd_count;
        opB(32'h1A0, db);
        check("midrst_line_invalid", 64'(rd_count - r0), 64'd1);

        for (int n = 0; n < 300; n++) begin
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad = (ad & 32'hFFFFF800) | 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) begin
                opB(ad, db);
            end else begin
                we = 2'($urandom_range(0, 3));
                re = 3'($urandom_range(0, 7));
                if (we == 2'b00 && re == 3'b000) re = 3'b011;
                opA(ad, we, re, $urandom, da);
            end
        end

        repeat (5) @(negedge clk);
        check("qa_drained", 64'(qa.size()), 64'd0);
        check("qb_drained", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ramio.md
# ramio

Cache front end between the CPU and the burst-mode external RAM. Two CPU ports share one direct-mapped, write-back cache: port A handles data (byte/half/word loads and stores) and port B handles instruction fetch (word reads only). Misses are served by whole-line bursts over the `br_` interface to the BurstRAM controller. The block sits between the core's load/store and fetch units and the BurstRAM.

## Interface
- `RAM_DEPTH_BITWIDTH`, default 8: width of `br_addr`; RAM holds 2^N 64-bit words.
- `RAM_BURST_DATA_COUNT`, default 4: beats per burst, which equals the beats per cache line.
- `RAM_BURST_DATA_BITWIDTH`, default 64: beat width. Only 64 is supported.
- `CACHE_LINE_IX_BITWIDTH`, default 1: log2 of the number of cache lines.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `enA` in 1: port A request.
- `weA` in 2: store size. 00 = none, 01 = byte, 10 = half, 11 = word.
- `reA` in 3: load. [1:0] is the size (01 = byte, 10 = half, 11 = word); [2] = sign-extend; 000 = none.
- `addrA` in 32: byte address.
- `dinA` in 32: store data, taken from the low bytes.
- `doutA` out 32: load result.
- `validA` out 1: `doutA` is valid.
- `bsyA` out 1: request not yet servable.
- `enB` in 1, `addrB` in 32, `doutB` out 32, `validB` out 1, `bsyB` out 1: instruction port, word reads only.
- `br_cmd` out 1: 0 = read, 1 = write.
- `br_cmd_en` out 1: command strobe.
- `br_addr` out `RAM_DEPTH_BITWIDTH`: word address of the line.
- `br_wr_data` out 64: write beat.
- `br_data_mask` out 8: 1 = byte masked. Always driven to 0.
- `br_rd_data` in 64: read beat.
- `br_rd_data_valid` in 1: read beat valid.
- `br_busy` in 1: RAM busy.

## Operation
- Line size is `RAM_BURST_DATA_COUNT*8` bytes (32 by default).
- Address split, from the low bits up: byte offset (`log2(line bytes)` bits), then line index (`CACHE_LINE_IX_BITWIDTH` bits), then tag (the remaining bits up to `RAM_DEPTH_BITWIDTH+3`). Higher address bits are ignored.
- Alignment is forced: halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. No access crosses a line.
- Byte order is little-endian. Line byte k lives in beat k/8, bits 8*(k%8)+:8. Beat i carries line bytes 8i..8i+7.
- Each line holds valid and dirty bits. Reset clears every valid and dirty bit.
- Lookup is combinational: hit = valid and tag match.
- Port A load, on hit: `doutA` is the selected byte or half, zero- or sign-extended to 32 bits, or the full word. `validA` = `enA` & (`reA` != 0) & hit. When not valid, `doutA` = 0.
- Port A store, on hit: the selected bytes are written at the rising edge and the dirty bit is set.
- If `weA` and `reA` are both nonzero, the store is performed and `doutA` shows the pre-store data.
- Port B: `doutB` is the aligned word on hit. `validB` = `enB` & hit.
- `bsyX` = `enX` & (miss | FSM not IDLE). The bsy outputs are held at 1 during reset.
- Miss servicing:
  - Port A has priority. B is served once A has no pending miss.
  - If the victim line is dirty, it is written back first. Then the new line is filled.
  - After the fill, valid is set, the tag is set and dirty is cleared.
  - The request then hits combinationally and bsy drops.
- FSM states:
  - IDLE: on a miss, go to WB if the victim is dirty, else RD.
  - WB: wait for !`br_busy`, then pulse `br_cmd_en` with `br_cmd`=1, the victim line address and beat 0. Send beats 1..N-1 on the following N-1 cycles, then go to RD.
  - RD: wait for !`br_busy`, then pulse `br_cmd_en` with `br_cmd`=0 and the new line address. Go to FILL.
  - FILL: store one beat per `br_rd_data_valid` cycle. After N beats, return to IDLE.

## Timing
- Hit load: 0 cycles. `doutA`/`doutB` are combinational from the address.
- Hit store: commits on the next rising edge.
- Clean miss: 1 command cycle, plus the RAM latency, plus N beats, plus 1 cycle to return to IDLE.
- Dirty miss adds N write cycles plus any `br_busy` wait.
- `br_cmd_en` is exactly one cycle wide. It is never asserted while `br_busy`=1.
- Reset mid-burst: the FSM returns to IDLE and all lines become invalid. Dirty data is lost.
- Reset values: `br_cmd_en`=0, `br_cmd`=0, `br_addr`=0, `br_wr_data`=0, `validA`=`validB`=0, `doutA`=`doutB`=0.

## Structure
- Package `ramio_pkg` holds the `weA` encodings, the `reA` size and sign encodings, the `br_cmd` codes, and the FSM state enum.
- One sub-module, `ramio_burst_ctrl`: the FSM plus beat counter that drives the `br_` signals.
- Line storage, tags and the port muxing stay in the top level.

## Test plan
- Store bytes 0x12, 0x34, 0x56, 0x78 to addresses 0..3, then load a word from 0 (`reA`=111): expect 0x78563412.
- Store halves 0x1234 at 4 and 0x5678 at 6: a word load from 4 returns 0x56781234; an unsigned half load from 6 returns 0x00005678; an unsigned byte load from 1 returns 0x34.
- Store word 0xFFFEFDFC at 8: signed byte loads from 8, 9, 10, 11 return -4, -3, -2, -1; signed half loads from 8 and 10 return -516 and -2.
- Store 0xDEADBEEF at 0, then read port B at 64 (same index): expect a write-back burst before the fill. A later load from 0 returns 0xDEADBEEF.
- Assert `enA` and `enB` on different missing lines together: A is filled first and B stays busy until its own fill completes.
- Hold `br_busy` high: `br_cmd_en` stays low until `br_busy` falls.
